// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared processor definitions used by the fetch front end: word width,
// reset vector default, NOP encoding and the prefetch queue entry layout.
package fetch_prefetch_unit_pkg;
   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
   localparam word_t NOP_INSTR        = 32'h0000_0000;

   typedef struct packed {
      word_t pc_plus4;
      word_t instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding prefetched instructions; power-of-two depth,
// synchronous clear for pipeline flushes and an occupancy count output.
module fetch_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_clr) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (i_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_count = r_count;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: credit-based issue to a one-cycle-latency imem,
// results queued in fetch_fifo; redirects flush and refetch.
module fetch_prefetch_unit
   import fetch_prefetch_unit_pkg::*;
#(
   parameter int    DEPTH    = 4,
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_q,
   output logic            out_valid,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc_plus4,
   output logic [XLEN-1:0] pc
);
   localparam int         CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   word_t        r_pc;
   logic         r_inflight;
   word_t        r_inflight_pc;

   logic [CW-1:0] w_count;
   logic [CW:0]   w_credit;
   logic          w_issue;
   logic          w_push;
   logic          w_pop;
   logic          w_valid;
   fetch_entry_t  w_wdata;
   fetch_entry_t  w_head;

   // The in-flight fetch already owns a slot, so it counts against the queue.
   assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue  = !redirect_valid && (w_credit < DEPTH_C);
   assign w_push   = r_inflight && !redirect_valid;
   assign w_valid  = (w_count != '0);
   assign w_pop    = w_valid && !stall && !redirect_valid;

   assign w_wdata.pc_plus4 = r_inflight_pc + 32'd4;
   assign w_wdata.instr    = imem_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (redirect_valid) begin
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc          <= r_pc + 32'd4;
            r_inflight_pc <= r_pc;
         end
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .i_rst_n (rst),
      .i_clr   (redirect_valid),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   assign imem_addr    = r_pc;
   assign pc           = r_pc;
   assign out_valid    = w_valid;
   assign out_instr    = w_valid ? w_head.instr    : NOP_INSTR;
   assign out_pc_plus4 = w_valid ? w_head.pc_plus4 : '0;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit; imem returns ~addr one cycle after
// the address edge, and delivered instructions are matched against a queue.
module tb_fetch_prefetch_unit;
   import fetch_prefetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] imem_addr;
   logic [31:0] imem_q;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic [31:0] pc;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pop   = 0;
   int   p0;

   always #5 clk = ~clk;

   always @(posedge clk) imem_q <= ~imem_addr;

   fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc_plus4   (out_pc_plus4),
      .pc             (pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start_stream(input logic [31:0] a, input int n);
      sb.delete();
      for (int k = 0; k < n; k++) begin
         exp_t e;
         e.instr = ~(a + 32'(4 * k));
         e.pc4   = a + 32'(4 * k + 4);
         sb.push_back(e);
      end
   endtask

   // Samples the head just after the inputs settle, consuming it when the DUT pops.
   task automatic cycle();
      #1;
      if (rst && out_valid && !stall && !redirect_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_underflow: got instr %h with no expected entry", out_instr);
         end else begin
            exp_t e = sb.pop_front();
            chk("pop_instr", out_instr, e.instr);
            chk("pop_pc4", out_pc_plus4, e.pc4);
            n_pop++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_pc4", out_pc_plus4, 32'h0);

      // Free run from reset.
      start_stream(32'h0, 64);
      rst = 1'b1;
      cycle();
      chk("e1_valid", 32'(out_valid), 32'h0);
      chk("e1_pc", pc, 32'h4);
      cycle();
      chk("e2_valid", 32'(out_valid), 32'h1);
      chk("e2_instr", out_instr, ~32'h0);
      chk("e2_pc4", out_pc_plus4, 32'h4);
      p0 = n_pop;
      repeat (9) cycle();
      chk("freerun_rate", 32'(n_pop - p0), 32'd9);

      // Stall from reset until the queue saturates.
      rst = 1'b0;
      @(negedge clk);
      rst   = 1'b1;
      stall = 1'b1;
      repeat (10) cycle();
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_instr", out_instr, ~32'h0);
      chk("stall_pc4", out_pc_plus4, 32'h4);
      start_stream(32'h0, 32);
      stall = 1'b0;
      p0 = n_pop;
      repeat (8) cycle();
      chk("drain_rate", 32'(n_pop - p0), 32'd8);

      // Redirect with three entries queued and one in flight, stall low.
      rst = 1'b0;
      @(negedge clk);
      rst   = 1'b1;
      stall = 1'b1;
      repeat (4) cycle();
      chk("pre_redir_instr", out_instr, ~32'h0);
      stall          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      start_stream(32'h100, 32);
      cycle();
      redirect_valid = 1'b0;
      chk("r0_valid", 32'(out_valid), 32'h0);
      chk("r0_pc", pc, 32'h100);
      cycle();
      chk("r1_valid", 32'(out_valid), 32'h0);
      chk("r1_pc", pc, 32'h104);
      cycle();
      chk("r2_valid", 32'(out_valid), 32'h1);
      chk("r2_instr", out_instr, ~32'h100);
      chk("r2_pc4", out_pc_plus4, 32'h104);
      p0 = n_pop;
      repeat (6) cycle();
      chk("redir_rate", 32'(n_pop - p0), 32'd6);

      // Asynchronous reset mid-cycle with a full queue.
      stall = 1'b1;
      repeat (8) cycle();
      chk("full_valid", 32'(out_valid), 32'h1);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_instr", out_instr, 32'h0);
      chk("arst_pc4", out_pc_plus4, 32'h0);
      chk("arst_pc", pc, 32'h0);
      @(negedge clk);
      start_stream(32'h0, 32);
      rst   = 1'b1;
      stall = 1'b0;
      cycle();
      cycle();
      chk("restart_valid", 32'(out_valid), 32'h1);
      chk("restart_instr", out_instr, ~32'h0);
      p0 = n_pop;
      repeat (4) cycle();
      chk("restart_rate", 32'(n_pop - p0), 32'd4);

      // Address wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      start_stream(32'hFFFF_FFFC, 16);
      cycle();
      redirect_valid = 1'b0;
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      cycle();
      chk("wrap_addr", imem_addr, 32'h0);
      cycle();
      chk("wrap_valid", 32'(out_valid), 32'h1);
      chk("wrap_pc4", out_pc_plus4, 32'h0);
      chk("wrap_instr", out_instr, 32'h3);
      p0 = n_pop;
      repeat (4) cycle();
      chk("wrap_rate", 32'(n_pop - p0), 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
